// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes,
// register-bank addresses, ALU op codes and the packed control word.
// Latency: n/a (definitions only). Backpressure: n/a.
package control_pkg;

    localparam int OPC_WIDTH   = 5;
    localparam int STATE_WIDTH = 4;

    // Explicit encodings so the debug state_m output is stable across builds.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_FETCH3 = 4'd4,
        ST_DECODE = 4'd5,
        ST_EX0    = 4'd6,
        ST_EX1    = 4'd7,
        ST_EX2    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDA  = 5'b00001;
    localparam logic [4:0] OP_STA  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_CA2  = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_INCD = 5'b01010;
    localparam logic [4:0] OP_JZ   = 5'b01011;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [2:0] REG_PC   = 3'd0;
    localparam logic [2:0] REG_DPTR = 3'd1;
    localparam logic [2:0] REG_A    = 3'd2;
    localparam logic [2:0] REG_TEMP = 3'd3;
    localparam logic [2:0] REG_MDR  = 3'd4;  // busB read only
    localparam logic [2:0] REG_ACC  = 3'd7;

    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_INC  = 3'b001;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SUB  = 3'b011;
    localparam logic [2:0] SEL_AND  = 3'b100;
    localparam logic [2:0] SEL_OR   = 3'b101;
    localparam logic [2:0] SEL_XOR  = 3'b110;
    localparam logic [2:0] SEL_CA2  = 3'b111;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LEFT = 2'b01;

    typedef struct packed {
        logic       ir_sclr;
        logic       mar_sclr;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busB_addr;
        logic [2:0] busC_addr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       mdr_alu_n;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // ADD..CA2 opcodes are laid out so that the ALU code is opcode-1.
    function automatic logic [2:0] alu_selop(input logic [4:0] op);
        logic [4:0] v;
        v = op - 5'd1;
        return v[2:0];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control interface between the sequencer and the memory_system datapath.
// Latency: n/a (wires only). Backpressure: none, run gates instruction fetch.
// master = sequencer (drives controls), slave = datapath side.
interface control_sequencer_if;
    import control_pkg::*;

    logic                   run;
    logic [OPC_WIDTH-1:0]   instruction;
    logic                   Z;

    logic                   ir_sclr;
    logic                   mar_sclr;
    logic                   enaf;
    logic [2:0]             selop;
    logic [1:0]             shamt;
    logic                   bank_wr_en;
    logic [2:0]             busB_addr;
    logic [2:0]             busC_addr;
    logic                   ir_en;
    logic                   mar_en;
    logic                   mdr_en;
    logic                   wr_rdn;
    logic                   mdr_alu_n;
    logic [STATE_WIDTH-1:0] state_m;
    logic                   halted;
    logic                   illegal;

    modport master (
        input  run, instruction, Z,
        output ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en,
               busB_addr, busC_addr, ir_en, mar_en, mdr_en, wr_rdn,
               mdr_alu_n, state_m, halted, illegal
    );

    modport slave (
        output run, instruction, Z,
        input  ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en,
               busB_addr, busC_addr, ir_en, mar_en, mdr_en, wr_rdn,
               mdr_alu_n, state_m, halted, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational map of (state, opcode, Z, run) to control word and next state.
// Latency: 0 cycles. Backpressure: i_run=0 holds FETCH0; nothing else stalls.
// Ports: i_state, i_instr (live IR, used in DECODE), i_opcode (latched), i_z, i_run -> o_ctrl, o_next.
module ctrl_decode
    import control_pkg::*;
(
    input  state_t     i_state,
    input  logic [4:0] i_instr,
    input  logic [4:0] i_opcode,
    input  logic       i_z,
    input  logic       i_run,
    output ctrl_t      o_ctrl,
    output state_t     o_next
);

    always_comb begin
        o_ctrl = '0;
        o_next = ST_INIT;
        case (i_state)
            ST_INIT: begin
                o_ctrl.ir_sclr  = 1'b1;
                o_ctrl.mar_sclr = 1'b1;
                o_next          = ST_FETCH0;
            end
            ST_FETCH0: begin
                o_ctrl.busB_addr = REG_PC;
                o_ctrl.selop     = SEL_PASS;
                o_ctrl.mar_en    = 1'b1;
                o_next           = i_run ? ST_FETCH1 : ST_FETCH0;
            end
            ST_FETCH1: begin
                o_ctrl.mdr_alu_n = 1'b1;
                o_ctrl.mdr_en    = 1'b1;
                o_next           = ST_FETCH2;
            end
            ST_FETCH2: begin
                o_ctrl.busB_addr = REG_MDR;
                o_ctrl.selop     = SEL_PASS;
                o_ctrl.ir_en     = 1'b1;
                o_next           = ST_FETCH3;
            end
            // PC increment gets its own cycle: the ALU is busy with the IR load in FETCH2.
            ST_FETCH3: begin
                o_ctrl.busB_addr  = REG_PC;
                o_ctrl.selop      = SEL_INC;
                o_ctrl.busC_addr  = REG_PC;
                o_ctrl.bank_wr_en = 1'b1;
                o_next            = ST_DECODE;
            end
            // IR is already stable here, so branch on the live instruction.
            ST_DECODE: begin
                case (i_instr)
                    OP_NOP: o_next = ST_FETCH0;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_CA2, OP_SHL, OP_INCD: o_next = ST_EX0;
                    OP_JZ:  o_next = i_z ? ST_EX0 : ST_FETCH0;
                    OP_HLT: o_next = ST_HALT;
                    default: begin
                        o_ctrl.illegal = 1'b1;
                        o_next         = ST_FETCH0;
                    end
                endcase
            end
            ST_EX0: begin
                o_next = ST_FETCH0;
                case (i_opcode)
                    OP_LDA, OP_STA: begin
                        o_ctrl.busB_addr = REG_DPTR;
                        o_ctrl.selop     = SEL_PASS;
                        o_ctrl.mar_en    = 1'b1;
                        o_next           = ST_EX1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CA2: begin
                        o_ctrl.busB_addr  = REG_ACC;
                        o_ctrl.selop      = alu_selop(i_opcode);
                        o_ctrl.busC_addr  = REG_ACC;
                        o_ctrl.bank_wr_en = 1'b1;
                        o_ctrl.enaf       = 1'b1;
                    end
                    OP_SHL: begin
                        o_ctrl.busB_addr  = REG_ACC;
                        o_ctrl.selop      = SEL_PASS;
                        o_ctrl.shamt      = SH_LEFT;
                        o_ctrl.busC_addr  = REG_ACC;
                        o_ctrl.bank_wr_en = 1'b1;
                        o_ctrl.enaf       = 1'b1;
                    end
                    OP_INCD: begin
                        o_ctrl.busB_addr  = REG_DPTR;
                        o_ctrl.selop      = SEL_INC;
                        o_ctrl.busC_addr  = REG_DPTR;
                        o_ctrl.bank_wr_en = 1'b1;
                    end
                    // Only reached when Z was set in DECODE.
                    OP_JZ: begin
                        o_ctrl.busB_addr  = REG_TEMP;
                        o_ctrl.selop      = SEL_PASS;
                        o_ctrl.busC_addr  = REG_PC;
                        o_ctrl.bank_wr_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EX1: begin
                o_next = ST_FETCH0;
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.mdr_alu_n = 1'b1;
                        o_ctrl.mdr_en    = 1'b1;
                        o_next           = ST_EX2;
                    end
                    OP_STA: begin
                        o_ctrl.busB_addr = REG_ACC;
                        o_ctrl.selop     = SEL_PASS;
                        o_ctrl.mdr_en    = 1'b1;
                        o_next           = ST_EX2;
                    end
                    default: ;
                endcase
            end
            ST_EX2: begin
                o_next = ST_FETCH0;
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.busB_addr  = REG_MDR;
                        o_ctrl.selop      = SEL_PASS;
                        o_ctrl.busC_addr  = REG_ACC;
                        o_ctrl.bank_wr_en = 1'b1;
                    end
                    OP_STA: o_ctrl.wr_rdn = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
                o_next        = ST_HALT;
            end
            // Unused encodings fall back to INIT.
            default: o_next = ST_INIT;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute sequencer driving every memory_system control.
// Latency: controls follow state combinationally; one state step per clk edge.
// Backpressure: bus.run=0 parks in FETCH0; HALT only exits through rst.
// Ports: clk, rst (async active-low), bus (control_sequencer_if.master).
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int ST_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master bus
);

    state_t           r_state;
    logic [OPC_W-1:0] r_opcode;
    state_t           w_next;
    ctrl_t            w_ctrl;

    // State resets asynchronously, so the INIT control word (sclr only)
    // appears the moment rst falls and any in-flight write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_INIT;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= bus.instruction;
            end
        end
    end

    ctrl_decode u_decode (
        .i_state  (r_state),
        .i_instr  (bus.instruction),
        .i_opcode (r_opcode),
        .i_z      (bus.Z),
        .i_run    (bus.run),
        .o_ctrl   (w_ctrl),
        .o_next   (w_next)
    );

    assign bus.ir_sclr    = w_ctrl.ir_sclr;
    assign bus.mar_sclr   = w_ctrl.mar_sclr;
    assign bus.enaf       = w_ctrl.enaf;
    assign bus.selop      = w_ctrl.selop;
    assign bus.shamt      = w_ctrl.shamt;
    assign bus.bank_wr_en = w_ctrl.bank_wr_en;
    assign bus.busB_addr  = w_ctrl.busB_addr;
    assign bus.busC_addr  = w_ctrl.busC_addr;
    assign bus.ir_en      = w_ctrl.ir_en;
    assign bus.mar_en     = w_ctrl.mar_en;
    assign bus.mdr_en     = w_ctrl.mdr_en;
    assign bus.wr_rdn     = w_ctrl.wr_rdn;
    assign bus.mdr_alu_n  = w_ctrl.mdr_alu_n;
    assign bus.halted     = w_ctrl.halted;
    assign bus.illegal    = w_ctrl.illegal;
    assign bus.state_m    = ST_W'(r_state);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: expected control words are queued
// per instruction and compared cycle by cycle as the sequencer steps.
module tb_control_sequencer;
    import control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_sclr;
        logic       mar_sclr;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bwe;
        logic [2:0] bb;
        logic [2:0] bc;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       mdr_alu_n;
        logic       halted;
        logic       illegal;
    } word_t;

    logic clk = 1'b0;
    logic rst;

    control_sequencer_if bus ();

    control_sequencer #(.OPC_W(5), .ST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    word_t sb[$];
    word_t e;
    word_t a;

    function automatic word_t sample();
        word_t w;
        w.st        = bus.state_m;
        w.ir_sclr   = bus.ir_sclr;
        w.mar_sclr  = bus.mar_sclr;
        w.enaf      = bus.enaf;
        w.selop     = bus.selop;
        w.shamt     = bus.shamt;
        w.bwe       = bus.bank_wr_en;
        w.bb        = bus.busB_addr;
        w.bc        = bus.busC_addr;
        w.ir_en     = bus.ir_en;
        w.mar_en    = bus.mar_en;
        w.mdr_en    = bus.mdr_en;
        w.wr_rdn    = bus.wr_rdn;
        w.mdr_alu_n = bus.mdr_alu_n;
        w.halted    = bus.halted;
        w.illegal   = bus.illegal;
        return w;
    endfunction

    function automatic word_t mk(input logic [3:0] st, input logic [2:0] bb, input logic [2:0] sel,
                                 input logic [2:0] bc, input logic bwe, input logic enaf,
                                 input logic [1:0] sh, input logic mar, input logic mdr,
                                 input logic ir, input logic wrrd, input logic src);
        word_t w;
        w           = '0;
        w.st        = st;
        w.bb        = bb;
        w.selop     = sel;
        w.bc        = bc;
        w.bwe       = bwe;
        w.enaf      = enaf;
        w.shamt     = sh;
        w.mar_en    = mar;
        w.mdr_en    = mdr;
        w.ir_en     = ir;
        w.wr_rdn    = wrrd;
        w.mdr_alu_n = src;
        return w;
    endfunction

    function automatic word_t w_init();
        word_t w;
        w          = '0;
        w.st       = 4'd0;
        w.ir_sclr  = 1'b1;
        w.mar_sclr = 1'b1;
        return w;
    endfunction

    function automatic word_t w_halt();
        word_t w;
        w        = '0;
        w.st     = 4'd9;
        w.halted = 1'b1;
        return w;
    endfunction

    // Fetch words straight from the state table.
    function automatic word_t w_f0(); return mk(4'd1, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 1, 0, 0, 0, 0); endfunction
    function automatic word_t w_f1(); return mk(4'd2, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 1); endfunction
    function automatic word_t w_f2(); return mk(4'd3, 3'd4, 3'b000, 3'd0, 0, 0, 2'b00, 0, 0, 1, 0, 0); endfunction
    function automatic word_t w_f3(); return mk(4'd4, 3'd0, 3'b001, 3'd0, 1, 0, 2'b00, 0, 0, 0, 0, 0); endfunction
    function automatic word_t w_dec(); return mk(4'd5, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0); endfunction

    task automatic test_reset();
        rst = 1'b0;
        #1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_hold got=%h want=%h", a, e); end
        @(posedge clk); #1;
        rst = 1'b1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_init_cycle got=%h want=%h", a, e); end
        @(posedge clk); #1;
        e = w_f0(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_to_fetch0 got=%h want=%h", a, e); end
        // Asynchronous assertion in the middle of a cycle.
        #3 rst = 1'b0;
        #1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_async got=%h want=%h", a, e); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        e = w_f0(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_release got=%h want=%h", a, e); end
    endtask

    task automatic test_run_hold();
        bus.run         = 1'b0;
        bus.instruction = OP_NOP;
        for (int i = 0; i < 10; i++) sb.push_back(w_f0());
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); a = sample(); vectors++;
            if (a !== e) begin miscompares++; $display("FAIL run_hold cycle %0d got=%h want=%h", i, a, e); end
        end
        bus.run = 1'b1;
        sb.push_back(w_f1()); sb.push_back(w_f2()); sb.push_back(w_f3());
        sb.push_back(w_dec()); sb.push_back(w_f0());
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); a = sample(); vectors++;
            if (a !== e) begin miscompares++; $display("FAIL run_release step %0d got=%h want=%h", i, a, e); end
        end
    endtask

    // Starts and ends in FETCH0; the queue holds every cycle of one instruction.
    task automatic test_instr(input logic [4:0] op, input logic z, input string name);
        word_t d;
        bus.instruction = op;
        bus.Z           = z;
        bus.run         = 1'b1;
        sb.push_back(w_f0()); sb.push_back(w_f1()); sb.push_back(w_f2()); sb.push_back(w_f3());
        d = w_dec();
        if (!(op inside {OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                         OP_CA2, OP_SHL, OP_INCD, OP_JZ, OP_HLT})) d.illegal = 1'b1;
        sb.push_back(d);
        case (op)
            OP_ADD: sb.push_back(mk(4'd6, 3'd7, 3'b010, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_SUB: sb.push_back(mk(4'd6, 3'd7, 3'b011, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_AND: sb.push_back(mk(4'd6, 3'd7, 3'b100, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_OR:  sb.push_back(mk(4'd6, 3'd7, 3'b101, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_XOR: sb.push_back(mk(4'd6, 3'd7, 3'b110, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_CA2: sb.push_back(mk(4'd6, 3'd7, 3'b111, 3'd7, 1, 1, 2'b00, 0, 0, 0, 0, 0));
            OP_SHL: sb.push_back(mk(4'd6, 3'd7, 3'b000, 3'd7, 1, 1, 2'b01, 0, 0, 0, 0, 0));
            OP_INCD: sb.push_back(mk(4'd6, 3'd1, 3'b001, 3'd1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
            OP_JZ: if (z) sb.push_back(mk(4'd6, 3'd3, 3'b000, 3'd0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
            OP_LDA: begin
                sb.push_back(mk(4'd6, 3'd1, 3'b000, 3'd0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
                sb.push_back(mk(4'd7, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 1));
                sb.push_back(mk(4'd8, 3'd4, 3'b000, 3'd7, 1, 0, 2'b00, 0, 0, 0, 0, 0));
            end
            OP_STA: begin
                sb.push_back(mk(4'd6, 3'd1, 3'b000, 3'd0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
                sb.push_back(mk(4'd7, 3'd7, 3'b000, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 0));
                sb.push_back(mk(4'd8, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 0, 0, 0, 1, 0));
            end
            default: ;
        endcase
        sb.push_back(w_f0());
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = sb.pop_front(); a = sample(); vectors++;
            if (a !== e) begin miscompares++; $display("FAIL %s step %0d got=%h want=%h", name, i, a, e); end
        end
        bus.Z = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.instruction = OP_LDA;
        bus.run         = 1'b1;
        sb.push_back(w_f0()); sb.push_back(w_f1()); sb.push_back(w_f2()); sb.push_back(w_f3());
        sb.push_back(w_dec());
        sb.push_back(mk(4'd6, 3'd1, 3'b000, 3'd0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        sb.push_back(mk(4'd7, 3'd0, 3'b000, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 1));
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = sb.pop_front(); a = sample(); vectors++;
            if (a !== e) begin miscompares++; $display("FAIL reset_mid_pre step %0d got=%h want=%h", i, a, e); end
        end
        #3 rst = 1'b0;
        #1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_mid_abort got=%h want=%h", a, e); end
        @(posedge clk); #1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_mid_held got=%h want=%h", a, e); end
        rst = 1'b1;
        @(posedge clk); #1;
        e = w_f0(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL reset_mid_restart got=%h want=%h", a, e); end
    endtask

    task automatic test_halt();
        bus.instruction = OP_HLT;
        bus.run         = 1'b1;
        sb.push_back(w_f0()); sb.push_back(w_f1()); sb.push_back(w_f2()); sb.push_back(w_f3());
        sb.push_back(w_dec()); sb.push_back(w_halt());
        for (int i = 0; i < 6; i++) sb.push_back(w_halt());
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) begin
                if (i > 5) bus.run = ~bus.run;
                @(posedge clk); #1;
            end
            e = sb.pop_front(); a = sample(); vectors++;
            if (a !== e) begin miscompares++; $display("FAIL halt step %0d got=%h want=%h", i, a, e); end
        end
        rst = 1'b0;
        #1;
        e = w_init(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL halt_reset got=%h want=%h", a, e); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        e = w_f0(); a = sample(); vectors++;
        if (a !== e) begin miscompares++; $display("FAIL halt_restart got=%h want=%h", a, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        bus.run         = 1'b0;
        bus.instruction = OP_NOP;
        bus.Z           = 1'b0;
        test_reset();
        test_run_hold();
        test_instr(OP_NOP,  1'b0, "nop");
        test_instr(OP_ADD,  1'b0, "add");
        test_instr(OP_SUB,  1'b1, "sub");
        test_instr(OP_AND,  1'b0, "and");
        test_instr(OP_OR,   1'b0, "or");
        test_instr(OP_XOR,  1'b0, "xor");
        test_instr(OP_CA2,  1'b0, "ca2");
        test_instr(OP_SHL,  1'b0, "shl");
        test_instr(OP_INCD, 1'b0, "incd");
        test_instr(OP_STA,  1'b0, "sta");
        test_instr(OP_LDA,  1'b0, "lda");
        test_instr(OP_JZ,   1'b1, "jz_taken");
        test_instr(OP_JZ,   1'b0, "jz_not_taken");
        test_instr(5'b10101, 1'b0, "illegal_10101");
        test_instr(5'b01100, 1'b1, "illegal_01100");
        test_instr(OP_ADD,  1'b0, "add_after_illegal");
        test_reset_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microprogrammed-style Moore FSM that sequences the memory_system datapath: fetch, decode, execute.
- Drives every memory_system control input (sclr, ALU op/shift, bank addresses/write, IR/MAR/MDR enables, read/write).
- Consumes the IR opcode and the Z flag.
- Sits beside memory_system at the CPU top level; the datapath has no other controller.

Parameters:
- OPC_W, 5, opcode width (matches memory_system instruction).
- ST_W, 4, width of the state_m debug output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets immediately).
- run  in  1  1 = allowed to leave FETCH0; 0 = hold in FETCH0.
- instruction  in  5  IR contents from memory_system.
- Z  in  1  zero flag from memory_system (registered flag).
- ir_sclr, mar_sclr  out  1  synchronous clears for IR/MAR.
- enaf  out  1  flag-update enable.
- selop  out  3  ALU op.
- shamt  out  2  ALU result shift.
- bank_wr_en  out  1  register bank write.
- busB_addr, busC_addr  out  3  bank read/write addresses.
- ir_en, mar_en, mdr_en  out  1  register load enables.
- wr_rdn  out  1  1 = memory write, 0 = read.
- mdr_alu_n  out  1  MDR source: 1 = memory, 0 = ALU.
- state_m  out  4  current state (debug).
- halted  out  1  1 in HALT.
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.

Behaviour:
- Moore outputs, decoded from state and latched opcode. Any control not listed for a state is 0.
- Reset (rst=0): state=INIT; ir_sclr=mar_sclr=1; all other outputs 0; halted=0.
- Bank map:
  - 0 = PC, 1 = DPTR, 2 = A, 3 = TEMP, 7 = ACC.
  - 4 = MDR; readable on busB only, never written.
- ALU selop map:
  - 000 PASS B, 001 INC B, 010 ADD A+B, 011 SUB B-A.
  - 100 AND, 101 OR, 110 XOR, 111 CA2 (two's complement of B).
- shamt: 00 except SHL, which uses 01.
- INIT: sclr=1 for one cycle, then FETCH0.
- FETCH0: busB=PC, PASS, mar_en=1. Stays in FETCH0 (mar_en still 1) while run=0. Advances when run=1.
- FETCH1: wr_rdn=0, mdr_alu_n=1, mdr_en=1.
- FETCH2:
  - busB=MDR, PASS, ir_en=1.
  - PC increment in the same cycle is not allowed (one ALU); goes to FETCH3.
- FETCH3: busB=PC, INC, busC=PC, bank_wr_en=1, enaf=0. Then DECODE.
- DECODE: no datapath action; latches opcode internally. Next state by opcode.
- Opcodes (instruction[4:0]) and execution:
  - 00000 NOP: back to FETCH0.
  - 00001 LDA, ACC<=mem[DPTR]:
    - EX0: busB=DPTR, PASS, mar_en.
    - EX1: read, mdr_alu_n=1, mdr_en.
    - EX2: busB=MDR, PASS, busC=ACC, bank_wr_en.
  - 00010 STA, mem[DPTR]<=ACC:
    - EX0: busB=DPTR, PASS, mar_en.
    - EX1: busB=ACC, PASS, mdr_alu_n=0, mdr_en.
    - EX2: wr_rdn=1.
  - 00011–01000 ADD, SUB, AND, OR, XOR, CA2:
    - One EX0 cycle: busB=ACC, selop = code per map, busC=ACC, bank_wr_en=1, enaf=1.
  - 01001 SHL: as above, with PASS and shamt=01, enaf=1.
  - 01010 INCD: busB=DPTR, INC, busC=DPTR, bank_wr_en; enaf=0.
  - 01011 JZ:
    - Z=1 (sampled in DECODE): EX0 = busB=TEMP, PASS, busC=PC, bank_wr_en.
    - Z=0: return to FETCH0 directly.
  - 11111 HLT: to HALT.
  - Other codes: illegal=1 in DECODE, treated as NOP.
- After the last EX cycle the FSM always returns to FETCH0.
- Cycle counts per instruction, FETCH0 through last EX inclusive, with run=1:
  - NOP: 5.
  - ALU ops, SHL, INCD, JZ taken: 6.
  - JZ not taken: 5.
  - LDA, STA: 8.
- enaf is 1 only for ALU/SHL execute cycles; never during fetch or INCD.
- HALT: all controls 0, halted=1. Exits only via reset; run is ignored.
- Reset mid-instruction: immediate return to INIT; no partial write completes after rst falls.
- Any unreachable state encoding recovers to INIT on the next clock.

Decomposition:
- Package control_pkg holds:
  - state enumeration and opcode constants;
  - bank address constants (REG_PC … REG_ACC, REG_MDR);
  - selop constants.
- Sub-module ctrl_decode: combinational block mapping (state, opcode, Z) to the control word and next state.
- The top level holds only the state and opcode registers.

Test Plan:
- Reset: rst=0 mid-cycle → all outputs 0 except ir_sclr=mar_sclr=1 asynchronously. After release: INIT for 1 cycle, then FETCH0.
- run=0 → FETCH0 held for 10 cycles (state_m constant, mar_en=1). run=1 → FETCH1 on the next edge.
- NOP (00000) → exact sequence FETCH0..FETCH3, DECODE, FETCH0. FETCH3 shows busB=busC=0, selop=001, bank_wr_en=1, enaf=0.
- CA2 (01000), ACC=0x05 in integrated bench → EX0 shows selop=111, busB=busC=7, enaf=1. ACC_m=0xFB afterwards, Z=0.
- STA then LDA with DPTR=0x10, ACC=0x3C:
  - STA EX2 shows wr_rdn=1.
  - LDA restores ACC_m=0x3C.
  - Each instruction takes 8 cycles.
- JZ with Z=1, TEMP=0x20 → PC_m=0x20. Z=0 → PC unchanged (incremented only).
- Opcode 10101 → illegal pulses for exactly 1 cycle, behaves as NOP.
- HLT → halted=1 and held; run toggling has no effect until rst=0.
